// File: rtl/spike_time_encoder.sv
// -----------------------------------------------------------------------------
// spike_time_encoder
//
// Temporal-code spike generator. It accepts one vector of per-line spike times
// over a valid/ready handshake. Each accepted vector is replayed as
// rising-edge-coded pulses during one gamma cycle of GAMMA_CYCLE_WIDTH slots.
// The block also produces the active-high per-gamma reset that the downstream
// WTA stage expects.
//
// Vectors are double-buffered: one vector plays from the active register while
// the next one waits in the pending register. This lets back-to-back gamma
// cycles run with no idle slot between them.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-low reset (0 = reset)
//   in_valid       a spike-time vector is offered
//   in_ready       the pending buffer is free, so a vector can be taken
//   in_times       line i spike time at bits [i*TIME_WIDTH +: TIME_WIDTH];
//                  the value GAMMA_CYCLE_WIDTH-1 is the null code (no spike)
//   output_spikes  registered spike lines
//   gamma_slot     current slot index, 0 when idle
//   gamma_rst      active-high reset for the downstream WTA
//   busy           a gamma cycle is in progress
// -----------------------------------------------------------------------------
module spike_time_encoder #(
    parameter int NUM_INPUTS        = 8,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    localparam int TIME_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*TIME_WIDTH-1:0] in_times,
    output logic [NUM_INPUTS-1:0]            output_spikes,
    output logic [TIME_WIDTH-1:0]            gamma_slot,
    output logic                             gamma_rst,
    output logic                             busy
);

    // The pulse-end compare is done wide enough that t + PULSE_WIDTH - 1 can
    // never wrap. Because of this, a late pulse is clipped instead of leaking
    // into slot 0 of the next gamma cycle.
    localparam int CMP_WIDTH = TIME_WIDTH + $clog2(PULSE_WIDTH) + 1;

    localparam logic [TIME_WIDTH-1:0] LAST_SLOT  = TIME_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CMP_WIDTH-1:0]  TRUNC_SLOT = CMP_WIDTH'(GAMMA_CYCLE_WIDTH - 2);
    localparam logic [CMP_WIDTH-1:0]  PULSE_SPAN = CMP_WIDTH'(PULSE_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                           state;
    state_t                           state_next;
    logic [TIME_WIDTH-1:0]            slot;
    logic [TIME_WIDTH-1:0]            slot_next;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] active_times;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] active_next;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] pending_times;
    logic                             pending_full;
    logic                             take_pending;
    logic [NUM_INPUTS-1:0]            spikes_next;
    logic                             gamma_rst_next;
    logic [CMP_WIDTH-1:0]             t_wide;
    logic [CMP_WIDTH-1:0]             end_wide;
    logic [CMP_WIDTH-1:0]             s_wide;

    assign in_ready   = !pending_full;
    assign busy       = (state == RUN);
    assign gamma_slot = slot;

    // Next-state logic for the gamma sequencer. A waiting vector is promoted
    // into the active register either when the block is idle, or on the last
    // slot of a running cycle. In the second case the new cycle starts with no
    // gap.
    always_comb begin
        state_next   = state;
        slot_next    = slot;
        active_next  = active_times;
        take_pending = 1'b0;
        case (state)
            IDLE: begin
                slot_next = '0;
                if (pending_full) begin
                    state_next   = RUN;
                    active_next  = pending_times;
                    take_pending = 1'b1;
                end
            end
            RUN: begin
                if (slot == LAST_SLOT) begin
                    slot_next = '0;
                    if (pending_full) begin
                        active_next  = pending_times;
                        take_pending = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    slot_next = slot + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                slot_next  = '0;
            end
        endcase
    end

    // Spike and gamma-reset values are computed from the *next* slot and the
    // *next* active vector. The registered outputs then line up exactly with
    // the registered gamma_slot. Pulses are clipped at the second-to-last
    // slot, so every line is low while gamma_rst is high. A null time
    // (GAMMA_CYCLE_WIDTH-1) lies past the clip point and never fires.
    always_comb begin
        spikes_next = '0;
        t_wide      = '0;
        end_wide    = '0;
        s_wide      = CMP_WIDTH'(slot_next);
        for (int i = 0; i < NUM_INPUTS; i++) begin
            t_wide   = CMP_WIDTH'(active_next[i*TIME_WIDTH +: TIME_WIDTH]);
            end_wide = t_wide + PULSE_SPAN;
            if (end_wide > TRUNC_SLOT) begin
                end_wide = TRUNC_SLOT;
            end
            if ((state_next == RUN) && (s_wide >= t_wide) && (s_wide <= end_wide)) begin
                spikes_next[i] = 1'b1;
            end
        end
        gamma_rst_next = (state_next == IDLE) || (slot_next == LAST_SLOT);
    end

    // State, buffers and registered outputs. Reset discards both buffered
    // vectors and forces the idle output pattern on the following cycle, so no
    // partial pulse survives the reset. A transfer is only possible while the
    // pending slot is empty, so a transfer never coincides with a promotion of
    // the pending vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            slot          <= '0;
            active_times  <= '0;
            pending_times <= '0;
            pending_full  <= 1'b0;
            output_spikes <= '0;
            gamma_rst     <= 1'b1;
        end else begin
            state         <= state_next;
            slot          <= slot_next;
            active_times  <= active_next;
            output_spikes <= spikes_next;
            gamma_rst     <= gamma_rst_next;
            if (take_pending) begin
                pending_full <= 1'b0;
            end else if (in_valid && in_ready) begin
                pending_times <= in_times;
                pending_full  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_time_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_time_encoder
//
// Directed bench for spike_time_encoder at the default sizes (8 lines,
// 16 slots, pulse width 8). Inputs are driven and outputs are sampled 1 time
// unit after each rising edge. Expected spike patterns are written per
// scenario from the hand-worked slot ranges.
// -----------------------------------------------------------------------------
module tb_spike_time_encoder;

    localparam int NUM_INPUTS = 8;
    localparam int G          = 16;
    localparam int P          = 8;
    localparam int TW         = 4;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_INPUTS*TW-1:0] in_times;
    logic [NUM_INPUTS-1:0]    output_spikes;
    logic [TW-1:0]            gamma_slot;
    logic                     gamma_rst;
    logic                     busy;

    int pass_count  = 0;
    int check_count = 0;

    spike_time_encoder #(
        .NUM_INPUTS       (NUM_INPUTS),
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_times     (in_times),
        .output_spikes(output_spikes),
        .gamma_slot   (gamma_slot),
        .gamma_rst    (gamma_rst),
        .busy         (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Put a vector (or nothing) on the handshake inputs.
    task automatic applyStimulus(input logic valid, input logic [31:0] times);
        in_valid = valid;
        in_times = times;
    endtask

    // Advance one clock and move just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs during one running slot.
    task automatic checkSlot(input string tag, input int s, input logic [7:0] exp_spikes,
                             input logic exp_ready);
        checkOutput($sformatf("%s s%0d slot", tag, s), 32'(gamma_slot), 32'(s));
        checkOutput($sformatf("%s s%0d spikes", tag, s), 32'(output_spikes), 32'(exp_spikes));
        checkOutput($sformatf("%s s%0d grst", tag, s), 32'(gamma_rst), 32'(s == G - 1));
        checkOutput($sformatf("%s s%0d busy", tag, s), 32'(busy), 32'd1);
        checkOutput($sformatf("%s s%0d ready", tag, s), 32'(in_ready), 32'(exp_ready));
    endtask

    // Check the idle output pattern.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " idle slot"}, 32'(gamma_slot), 32'd0);
        checkOutput({tag, " idle spikes"}, 32'(output_spikes), 32'd0);
        checkOutput({tag, " idle grst"}, 32'(gamma_rst), 32'd1);
        checkOutput({tag, " idle ready"}, 32'(in_ready), 32'd1);
    endtask

    // Main directed sequence.
    initial begin
        logic [7:0] exp;
        int         first_on [NUM_INPUTS];

        rst = 1'b0;
        applyStimulus(1'b0, 32'h0);
        step();
        step();
        checkIdle("reset");
        rst = 1'b1;
        step();

        // Single vector: line 0 at t=3, all other lines null.
        applyStimulus(1'b1, 32'hFFFF_FFF3);
        step();
        applyStimulus(1'b0, 32'h0);
        checkOutput("t1 ready after accept", 32'(in_ready), 32'd0);
        checkOutput("t1 busy before start", 32'(busy), 32'd0);
        step();
        for (int s = 0; s < G; s++) begin
            exp = {7'b0, (s >= 3 && s <= 10)};
            checkSlot("t1", s, exp, 1'b1);
            step();
        end
        checkIdle("t1");

        // Truncation and boundary times: line2=12, line5=0, line7=14.
        applyStimulus(1'b1, 32'hEF0F_FCFF);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        for (int s = 0; s < G; s++) begin
            exp = '0;
            exp[2] = (s >= 12 && s <= 14);
            exp[5] = (s <= 7);
            exp[7] = (s == 14);
            checkSlot("t2", s, exp, 1'b1);
            step();
        end
        checkIdle("t2");

        // Back-to-back cycles. V2 is accepted in slot 0 of the first cycle.
        // V3 is then held valid while the pending buffer is full, and is only
        // taken in slot 0 of the second cycle. The in_times bus is scrambled
        // after V3 is taken.
        applyStimulus(1'b1, 32'hFFFF_FFF3);
        step();
        applyStimulus(1'b1, 32'hFFFF_FF0F);
        checkOutput("t3 ready pending", 32'(in_ready), 32'd0);
        step();
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < G; s++) begin
                exp = '0;
                if (c == 0) exp[0] = (s >= 3 && s <= 10);
                if (c == 1) exp[1] = (s <= 7);
                if (c == 2) exp[3] = (s == 14);
                checkSlot($sformatf("t3 c%0d", c), s, exp, (c == 2) ? 1'b1 : (s == 0));
                if (c == 0 && s == 1) applyStimulus(1'b1, 32'hFFFF_EFFF);
                if (c == 1 && s == 1) applyStimulus(1'b0, 32'h0000_0000);
                step();
            end
        end
        checkIdle("t3");

        // Mid-gamma reset with line 1 pulsing and a vector waiting.
        applyStimulus(1'b1, 32'hFFFF_FF4F);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        for (int s = 0; s <= 6; s++) begin
            exp = '0;
            exp[1] = (s >= 4);
            checkSlot("t5", s, exp, (s <= 2));
            if (s == 2) applyStimulus(1'b1, 32'hFFFF_FFF0);
            if (s == 3) applyStimulus(1'b0, 32'h0);
            if (s < 6) step();
        end
        rst = 1'b0;
        step();
        checkIdle("t5 rst");
        rst = 1'b1;
        for (int k = 0; k < 20; k++) step();
        checkIdle("t5 lost");

        // Onset order as seen by a downstream WTA: times {5,6,2,4,null x4}.
        for (int i = 0; i < NUM_INPUTS; i++) first_on[i] = 99;
        applyStimulus(1'b1, 32'hFFFF_4265);
        step();
        applyStimulus(1'b0, 32'h0);
        step();
        for (int s = 0; s < G; s++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (output_spikes[i] && first_on[i] == 99) first_on[i] = s;
            end
            step();
        end
        checkOutput("t6 onset line2", 32'(first_on[2]), 32'd2);
        checkOutput("t6 onset line3", 32'(first_on[3]), 32'd4);
        checkOutput("t6 onset line0", 32'(first_on[0]), 32'd5);
        checkOutput("t6 onset line1", 32'(first_on[1]), 32'd6);
        for (int i = 4; i < NUM_INPUTS; i++) begin
            checkOutput($sformatf("t6 null line%0d", i), 32'(first_on[i]), 32'd99);
        end
        checkIdle("t6");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
